// File: rtl/logic_op_sequencer.sv
// Operand-side controller for a 4-bit logic unit: gathers X, Y and op select from a
// strobed nibble bus, waits a settle interval, then captures and holds the 8-bit result.
module logic_op_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [3:0]         i_data_in,
    input  logic               i_data_strobe,
    input  logic               i_clear,
    input  logic [7:0]         i_result_in,
    output logic [3:0]         o_op_x,
    output logic [3:0]         o_op_y,
    output logic [1:0]         o_op_sel,
    output logic [7:0]         o_result_out,
    output logic               o_result_valid,
    output logic               o_busy,
    output logic [2:0]         o_stage,
    output logic [COUNT_W-1:0] o_op_count
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_LOAD_X  = 3'd0,
        ST_LOAD_Y  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic [3:0]         r_op_x;
    logic [3:0]         r_op_y;
    logic [1:0]         r_op_sel;
    logic [7:0]         r_result;
    logic               r_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_settle;
    logic [COUNT_W-1:0] r_op_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_LOAD_X;
            r_op_x     <= '0;
            r_op_y     <= '0;
            r_op_sel   <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_settle   <= '0;
            r_op_count <= '0;
        end else if (i_clear) begin
            // Abort keeps the completed-operation tally; an interrupted settle never counts.
            r_state  <= ST_LOAD_X;
            r_op_x   <= '0;
            r_op_y   <= '0;
            r_op_sel <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_settle <= '0;
        end else begin
            case (r_state)
                ST_LOAD_X: begin
                    if (i_data_strobe) begin
                        r_op_x  <= i_data_in;
                        r_state <= ST_LOAD_Y;
                    end
                end
                ST_LOAD_Y: begin
                    if (i_data_strobe) begin
                        r_op_y  <= i_data_in;
                        r_state <= ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (i_data_strobe) begin
                        r_op_sel <= i_data_in[1:0];
                        r_settle <= SETTLE_LOAD;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else begin
                        r_result   <= i_result_in;
                        r_valid    <= 1'b1;
                        r_op_count <= r_op_count + 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A strobe here is already the next X nibble, so restart without losing it.
                    if (i_data_strobe) begin
                        r_op_x  <= i_data_in;
                        r_valid <= 1'b0;
                        r_state <= ST_LOAD_Y;
                    end
                end
                default: begin
                    r_state <= ST_LOAD_X;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_op_x         = r_op_x;
    assign o_op_y         = r_op_y;
    assign o_op_sel       = r_op_sel;
    assign o_result_out   = r_result;
    assign o_result_valid = r_valid;
    assign o_busy         = r_busy;
    assign o_stage        = r_state;
    assign o_op_count     = r_op_count;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: two instances (settle 2 and settle 1) each driving a
// behavioural logic unit; directed scenarios followed by randomized operations.
module tb_logic_op_sequencer;

    localparam int SETTLE_A = 2;
    localparam int SETTLE_B = 1;

    logic clk;
    logic rst;

    logic [3:0] a_data;
    logic       a_strobe;
    logic       a_clear;
    logic [7:0] a_rin;
    logic [3:0] a_x;
    logic [3:0] a_y;
    logic [1:0] a_sel;
    logic [7:0] a_res;
    logic       a_valid;
    logic       a_busy;
    logic [2:0] a_stage;
    logic [7:0] a_count;

    logic [3:0] b_data;
    logic       b_strobe;
    logic       b_clear;
    logic [7:0] b_rin;
    logic [3:0] b_x;
    logic [3:0] b_y;
    logic [1:0] b_sel;
    logic [7:0] b_res;
    logic       b_valid;
    logic       b_busy;
    logic [2:0] b_stage;
    logic [7:0] b_count;

    int n_chk;
    int n_fail;
    int exp_cnt_a;
    int exp_cnt_b;
    logic [7:0] m_res_a;
    logic [7:0] m_res_b;

    // Behavioural logic unit: AND/OR/XOR in the low nibble, NOT gives {~X, ~Y}.
    function automatic logic [7:0] lu(input logic [3:0] x, input logic [3:0] y, input logic [1:0] s);
        case (s)
            2'd0:    return {4'h0, x & y};
            2'd1:    return {4'h0, x | y};
            2'd2:    return {4'h0, x ^ y};
            default: return {~x, ~y};
        endcase
    endfunction

    assign a_rin = lu(a_x, a_y, a_sel);
    assign b_rin = lu(b_x, b_y, b_sel);

    logic_op_sequencer #(.SETTLE_CYCLES(SETTLE_A), .COUNT_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data_in(a_data), .i_data_strobe(a_strobe),
        .i_clear(a_clear), .i_result_in(a_rin), .o_op_x(a_x), .o_op_y(a_y),
        .o_op_sel(a_sel), .o_result_out(a_res), .o_result_valid(a_valid),
        .o_busy(a_busy), .o_stage(a_stage), .o_op_count(a_count)
    );

    logic_op_sequencer #(.SETTLE_CYCLES(SETTLE_B), .COUNT_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data_in(b_data), .i_data_strobe(b_strobe),
        .i_clear(b_clear), .i_result_in(b_rin), .o_op_x(b_x), .o_op_y(b_y),
        .o_op_sel(b_sel), .o_result_out(b_res), .o_result_valid(b_valid),
        .o_busy(b_busy), .o_stage(b_stage), .o_op_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [3:0] d);
        a_data   = d;
        a_strobe = 1'b1;
        tick();
        a_strobe = 1'b0;
    endtask

    task automatic strobe_b(input logic [3:0] d);
        b_data   = d;
        b_strobe = 1'b1;
        tick();
        b_strobe = 1'b0;
    endtask

    // One full operation on instance A; works from LOAD_X or from DONE.
    task automatic run_a(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op,
                         input logic [7:0] exp_res);
        logic [1:0] junk;
        junk = 2'($urandom);
        strobe_a(x);
        chk("a_x_load", 32'(a_x), 32'(x));
        chk("a_stage_y", 32'(a_stage), 32'd1);
        chk("a_valid_drop", 32'(a_valid), 32'd0);
        chk("a_res_hold", 32'(a_res), 32'(m_res_a));
        strobe_a(y);
        chk("a_y_load", 32'(a_y), 32'(y));
        strobe_a({junk, op});
        chk("a_sel_load", 32'(a_sel), 32'(op));
        chk("a_busy_settle", 32'(a_busy), 32'd1);
        repeat (SETTLE_A - 1) begin
            tick();
            chk("a_valid_early", 32'(a_valid), 32'd0);
        end
        tick();
        exp_cnt_a++;
        m_res_a = exp_res;
        chk("a_result", 32'(a_res), 32'(exp_res));
        chk("a_valid", 32'(a_valid), 32'd1);
        chk("a_count", 32'(a_count), 32'(exp_cnt_a & 255));
        chk("a_stage_done", 32'(a_stage), 32'd4);
        chk("a_busy_done", 32'(a_busy), 32'd0);
    endtask

    initial begin
        logic [3:0] rx;
        logic [3:0] ry;
        logic [1:0] rop;
        n_chk = 0;
        n_fail = 0;
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        m_res_a = 8'h00;
        m_res_b = 8'h00;
        rst = 1'b0;
        a_data = 4'h0; a_strobe = 1'b0; a_clear = 1'b0;
        b_data = 4'h0; b_strobe = 1'b0; b_clear = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_stage", 32'(a_stage), 32'd0);
        chk("rst_x", 32'(a_x), 32'd0);
        chk("rst_y", 32'(a_y), 32'd0);
        chk("rst_sel", 32'(a_sel), 32'd0);
        chk("rst_res", 32'(a_res), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_b_count", 32'(b_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_stage", 32'(a_stage), 32'd0);

        // Directed: AND, then OR/XOR/NOT each restarted straight from DONE.
        run_a(4'hA, 4'hC, 2'd0, 8'h08);
        run_a(4'hA, 4'hC, 2'd1, 8'h0E);
        run_a(4'hA, 4'hC, 2'd2, 8'h06);
        run_a(4'hA, 4'hC, 2'd3, 8'h53);

        // Strobes during SETTLE are ignored and capture timing is unchanged.
        strobe_a(4'h3);
        strobe_a(4'h5);
        strobe_a(4'h1);
        chk("ign_busy", 32'(a_busy), 32'd1);
        strobe_a(4'hF);
        chk("ign_x", 32'(a_x), 32'h3);
        chk("ign_y", 32'(a_y), 32'h5);
        chk("ign_sel", 32'(a_sel), 32'h1);
        chk("ign_valid_early", 32'(a_valid), 32'd0);
        strobe_a(4'hF);
        exp_cnt_a++;
        m_res_a = 8'h07;
        chk("ign_result", 32'(a_res), 32'h07);
        chk("ign_valid", 32'(a_valid), 32'd1);
        chk("ign_count", 32'(a_count), 32'(exp_cnt_a));
        chk("ign_x_after", 32'(a_x), 32'h3);
        tick();
        chk("done_hold_stage", 32'(a_stage), 32'd4);
        chk("done_hold_valid", 32'(a_valid), 32'd1);
        chk("done_hold_res", 32'(a_res), 32'h07);

        // Clear together with a strobe in SETTLE.
        strobe_a(4'h6);
        strobe_a(4'h9);
        strobe_a(4'h2);
        a_clear = 1'b1;
        a_data = 4'hF;
        a_strobe = 1'b1;
        tick();
        a_clear = 1'b0;
        a_strobe = 1'b0;
        m_res_a = 8'h00;
        chk("clr_stage", 32'(a_stage), 32'd0);
        chk("clr_x", 32'(a_x), 32'd0);
        chk("clr_y", 32'(a_y), 32'd0);
        chk("clr_sel", 32'(a_sel), 32'd0);
        chk("clr_res", 32'(a_res), 32'd0);
        chk("clr_valid", 32'(a_valid), 32'd0);
        chk("clr_busy", 32'(a_busy), 32'd0);
        chk("clr_count", 32'(a_count), 32'(exp_cnt_a));
        tick();
        tick();
        chk("clr_no_capture_cnt", 32'(a_count), 32'(exp_cnt_a));
        chk("clr_no_capture_stage", 32'(a_stage), 32'd0);

        // Asynchronous reset between edges in the middle of SETTLE.
        strobe_a(4'h7);
        strobe_a(4'hE);
        strobe_a(4'h2);
        #3 rst = 1'b1;
        #1;
        chk("arst_x", 32'(a_x), 32'd0);
        chk("arst_y", 32'(a_y), 32'd0);
        chk("arst_stage", 32'(a_stage), 32'd0);
        chk("arst_busy", 32'(a_busy), 32'd0);
        chk("arst_count", 32'(a_count), 32'd0);
        #2 rst = 1'b0;
        exp_cnt_a = 0;
        m_res_a = 8'h00;
        repeat (3) tick();
        chk("arst_no_capture_valid", 32'(a_valid), 32'd0);
        chk("arst_no_capture_res", 32'(a_res), 32'd0);
        chk("arst_no_capture_cnt", 32'(a_count), 32'd0);
        chk("arst_stage_idle", 32'(a_stage), 32'd0);

        // Randomized operations on the settle-2 instance.
        for (int i = 0; i < 20; i++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            rop = 2'($urandom);
            run_a(rx, ry, rop, lu(rx, ry, rop));
        end

        // Settle-1 instance: 256 random ops, capture one edge after the op strobe, count wraps.
        for (int i = 0; i < 256; i++) begin
            rx = 4'($urandom);
            ry = 4'($urandom);
            rop = 2'($urandom);
            strobe_b(rx);
            chk("b_valid_drop", 32'(b_valid), 32'd0);
            chk("b_res_hold", 32'(b_res), 32'(m_res_b));
            strobe_b(ry);
            strobe_b({2'($urandom), rop});
            chk("b_busy", 32'(b_busy), 32'd1);
            chk("b_valid_early", 32'(b_valid), 32'd0);
            tick();
            exp_cnt_b++;
            m_res_b = lu(rx, ry, rop);
            chk("b_result", 32'(b_res), 32'(m_res_b));
            chk("b_valid", 32'(b_valid), 32'd1);
            chk("b_count", 32'(b_count), 32'(exp_cnt_b & 255));
        end
        chk("b_wrap", 32'(b_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
